mem_arbiter: RTL and testbench

- Round-robin arbiter sharing the node's single-port learning memory between up to NUM_REQ requesters (reward, Q-update, cluster-head election, etc.).
- Each requester presents an address, write data and write strobe; the arbiter grants exclusive ownership, muxes the owner onto the memory port and broadcasts read data.
- Ownership lasts until the owner signals done or drops its request.
- A watchdog forcibly revokes a grant held too long.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_rr_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the learning-memory arbiter: word width, FSM encoding, index helper.
// Pure declarations; no latency or backpressure of its own.
package mem_arbiter_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ID_W       = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping mod N.
// Zero latency; no backpressure, vld low when nothing requests.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [N-1:0]     oh,
    output logic [IDX_W-1:0] idx
);

    // Walk the rotation backwards so the last hit written is the closest to ptr.
    always_comb begin
        vld = 1'b0;
        oh  = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                vld   = 1'b1;
                oh    = '0;
                oh[j] = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner arbitration of the single-port learning memory with hold watchdog.
// Grant one edge after req; owner holds the port until done/req drop/timeout, 2-cycle regrant gap.
module mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WORD_WIDTH = mem_arbiter_pkg::WORD_WIDTH,
    parameter int MAX_HOLD   = 64,
    parameter int CNT_W      = 8
) (
    input  logic                          clock,
    input  logic                          nrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            done_in,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic                          clr_err,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [2:0]                    grant_id,
    output logic                          busy,
    output logic [WORD_WIDTH-1:0]         mem_addr,
    output logic [WORD_WIDTH-1:0]         mem_wdata,
    output logic                          mem_wr,
    input  logic [WORD_WIDTH-1:0]         mem_rdata,
    output logic [WORD_WIDTH-1:0]         rdata,
    output logic                          timeout_err,
    output logic [2:0]                    err_id
);

    import mem_arbiter_pkg::*;

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  hold_cnt;
    logic              pick_vld;
    logic [NUM_REQ-1:0] pick_oh;
    logic [ID_W-1:0]   pick_idx;
    logic              owner_release;
    logic              hold_expired;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .oh  (pick_oh),
        .idx (pick_idx)
    );

    // gnt is one-hot only in OWN, so masking with it selects the owner and ignores everyone else.
    assign owner_release = |(gnt & done_in) | ~|(gnt & req);
    assign hold_expired  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign mem_wr        = |(gnt & req_wr);
    assign rdata         = mem_rdata;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mem_addr  = mem_addr  | req_addr[i*WORD_WIDTH +: WORD_WIDTH];
                mem_wdata = mem_wdata | req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or posedge nrst) begin
        if (nrst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            gnt         <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err_id      <= '0;
        end else begin
            if (clr_err) timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= OWN;
                        gnt      <= pick_oh;
                        grant_id <= pick_idx;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                OWN: begin
                    if (owner_release || hold_expired) begin
                        state  <= RELEASE;
                        gnt    <= '0;
                        rr_ptr <= wrap_inc(grant_id, NUM_REQ);
                        // A release landing on the expiry cycle is a clean release.
                        if (!owner_release) begin
                            timeout_err <= 1'b1;
                            err_id      <= grant_id;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written timeout/reset sequences.
module tb_mem_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic             clock = 1'b0;
    logic             nrst;
    logic [N-1:0]     req, done_in, req_wr, gnt;
    logic [N*W-1:0]   req_addr, req_wdata;
    logic             clr_err, busy, mem_wr, timeout_err;
    logic [2:0]       grant_id, err_id;
    logic [W-1:0]     mem_addr, mem_wdata, mem_rdata, rdata;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_arbiter #(
        .NUM_REQ    (N),
        .WORD_WIDTH (W),
        .MAX_HOLD   (64),
        .CNT_W      (8)
    ) dut (
        .clock       (clock),
        .nrst        (nrst),
        .req         (req),
        .done_in     (done_in),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wr      (req_wr),
        .clr_err     (clr_err),
        .gnt         (gnt),
        .grant_id    (grant_id),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wr      (mem_wr),
        .mem_rdata   (mem_rdata),
        .rdata       (rdata),
        .timeout_err (timeout_err),
        .err_id      (err_id)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  done;
        logic [3:0]  wr;
        logic [3:0]  e_gnt;
        logic [2:0]  e_id;
        logic        e_busy;
        logic        e_wr;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        nrst    = 1'b1;
        req     = '0;
        done_in = '0;
        req_wr  = '0;
        clr_err = 1'b0;
        tick;
        tick;
        nrst = 1'b0;
    endtask

    initial begin
        int cnt;
        int low;
        logic [3:0] order[5];
        logic [15:0] exp_wd;

        for (int i = 0; i < N; i++) begin
            req_addr[i*W +: W]  = 16'h0048 | 16'(i << 8);
            req_wdata[i*W +: W] = 16'hA000 + 16'(i);
        end
        mem_rdata = 16'hBEEF;

        //            req      done     wr       gnt      id    busy  wr    addr
        vecs[0] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 3'd1, 1'b1, 1'b1, 16'h0148};
        vecs[1] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 3'd1, 1'b1, 1'b0, 16'h0148};
        vecs[2] = '{4'b1010, 4'b1000, 4'b1000, 4'b0010, 3'd1, 1'b1, 1'b0, 16'h0148};
        vecs[3] = '{4'b1010, 4'b1000, 4'b1010, 4'b0010, 3'd1, 1'b1, 1'b1, 16'h0148};
        vecs[4] = '{4'b1010, 4'b0010, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0, 16'h0000};
        vecs[5] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{4'b1010, 4'b0000, 4'b0000, 4'b1000, 3'd3, 1'b1, 1'b0, 16'h0348};
        order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        do_reset;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_err_id", 32'(err_id), 0);
        chk("rdata_pass", 32'(rdata), 32'h0000BEEF);

        // Single grant, address mux, non-owner done/wr ignored, rr_ptr advance
        for (int v = 0; v < 7; v++) begin
            req     = vecs[v].req;
            done_in = vecs[v].done;
            req_wr  = vecs[v].wr;
            tick;
            exp_wd = (vecs[v].e_gnt != 0) ? 16'hA000 + 16'(vecs[v].e_id) : 16'h0000;
            chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].e_gnt));
            chk($sformatf("vec%0d_grant_id", v), 32'(grant_id), 32'(vecs[v].e_id));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
            chk($sformatf("vec%0d_mem_wr", v), 32'(mem_wr), 32'(vecs[v].e_wr));
            chk($sformatf("vec%0d_mem_addr", v), 32'(mem_addr), 32'(vecs[v].e_addr));
            chk($sformatf("vec%0d_mem_wdata", v), 32'(mem_wdata), 32'(exp_wd));
        end

        // Full rotation with everyone requesting, 2-cycle gap between owners
        do_reset;
        req = 4'b1111;
        low = 0;
        for (int g = 0; g < 5; g++) begin
            for (int t = 0; t < 10; t++) begin
                tick;
                if (gnt != 0) break;
                low++;
            end
            chk($sformatf("rot%0d_gnt", g), 32'(gnt), 32'(order[g]));
            chk($sformatf("rot%0d_onehot", g), 32'($onehot(gnt)), 1);
            if (g > 0) chk($sformatf("rot%0d_gap", g), 32'(low), 2);
            tick;
            tick;
            done_in = order[g];
            tick;
            done_in = '0;
            chk($sformatf("rot%0d_release", g), 32'(gnt), 0);
            low = 1;
        end
        req = '0;

        // Watchdog on owner 2, with clr_err colliding with the timeout edge
        do_reset;
        req = 4'b0100;
        tick;
        chk("wd_gnt", 32'(gnt), 32'h4);
        chk("wd_grant_id", 32'(grant_id), 2);
        cnt = 1;
        for (int t = 0; t < 100; t++) begin
            if (cnt == 64) clr_err = 1'b1;
            tick;
            if (gnt != 4'b0100) break;
            cnt++;
        end
        clr_err = 1'b0;
        chk("wd_hold_cycles", 32'(cnt), 64);
        chk("wd_timeout_set_wins", 32'(timeout_err), 1);
        chk("wd_err_id", 32'(err_id), 2);
        chk("wd_busy_release", 32'(busy), 1);
        req = '0;
        tick;
        tick;
        chk("wd_sticky", 32'(timeout_err), 1);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("wd_clr", 32'(timeout_err), 0);

        // done on the expiry cycle is a normal release
        do_reset;
        req = 4'b0001;
        tick;
        cnt = 1;
        for (int t = 0; t < 100; t++) begin
            if (cnt == 64) done_in = 4'b0001;
            tick;
            if (gnt != 4'b0001) break;
            cnt++;
        end
        done_in = '0;
        chk("edge_hold_cycles", 32'(cnt), 64);
        chk("edge_no_timeout", 32'(timeout_err), 0);
        req    = 4'b1111;
        req_wr = 4'b0010;
        tick;
        tick;
        chk("edge_next_owner", 32'(gnt), 32'h2);
        chk("edge_mem_wr", 32'(mem_wr), 1);

        // Asynchronous reset mid-ownership, then restart from index 0
        #2;
        nrst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_mem_wr", 32'(mem_wr), 0);
        chk("arst_busy", 32'(busy), 0);
        req    = 4'b1001;
        req_wr = '0;
        @(negedge clock);
        nrst = 1'b0;
        tick;
        chk("arst_first_gnt", 32'(gnt), 32'h1);
        chk("arst_first_id", 32'(grant_id), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
